// File: rtl/countdown_timer_ctrl.sv
// Countdown-timer controller: clock-enable prescaler plus a loadable seconds
// countdown sequenced by load/start/pause/clear, with per-tick and expiry pulses.
module countdown_timer_ctrl #(
  parameter int CLK_HZ  = 10000000,
  parameter int TICK_HZ = 1,
  parameter int CW      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic       tick,
  output logic [7:0] remaining,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);

  localparam int          DIV     = CLK_HZ / TICK_HZ;
  localparam logic [CW-1:0] PRE_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] presc, presc_n;
  logic [7:0]    rem_n;
  logic          tick_n, done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= IDLE;
      presc     <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur       <= nxt;
      presc     <= presc_n;
      remaining <= rem_n;
      tick      <= tick_n;
      done      <= done_n;
    end
  end

  always_comb begin
    nxt     = cur;
    presc_n = presc;
    rem_n   = remaining;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    if (clear) begin
      nxt     = IDLE;
      presc_n = '0;
      rem_n   = '0;
    end else begin
      case (cur)
        IDLE: begin
          if (load) begin
            rem_n = load_val;
          end else if (start && remaining != 8'd0) begin
            nxt     = RUN;
            presc_n = '0;
          end
        end
        RUN: begin
          // pause beats a coincident wrap; prescaler value is held for resume
          if (pause) begin
            nxt = PAUSED;
          end else if (presc == PRE_MAX) begin
            presc_n = '0;
            tick_n  = 1'b1;
            rem_n   = remaining - 8'd1;
            if (remaining == 8'd1) begin
              nxt    = EXPIRED;
              done_n = 1'b1;
            end
          end else begin
            presc_n = presc + CW'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) nxt = RUN;
        end
        EXPIRED: begin
          presc_n = '0;
          if (load) begin
            rem_n = load_val;
            nxt   = IDLE;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  assign state   = cur;
  assign running = (cur == RUN);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with DIV=10; expected values hand-derived.
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset, clear, load, start, pause;
  logic [7:0] load_val;
  logic       tick, running, done;
  logic [7:0] remaining;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  countdown_timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .CW(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick), .remaining(remaining),
    .running(running), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [7:0] rem,
                         input logic tk, input logic dn);
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".remaining"}, remaining, rem);
    chk({tag, ".tick"}, 8'(tick), 8'(tk));
    chk({tag, ".done"}, 8'(done), 8'(dn));
    chk({tag, ".running"}, 8'(running), 8'(st == 2'b01));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
    cyc(2);
    reset = 1'b0;
    chk_all("reset_init", 2'b00, 8'd0, 1'b0, 1'b0);

    // full countdown from 3
    load = 1'b1; load_val = 8'd3; cyc(1); load = 1'b0;
    chk_all("load3", 2'b00, 8'd3, 1'b0, 1'b0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk_all("start3", 2'b01, 8'd3, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      chk("full.tick", 8'(tick), 8'(k % 10 == 0));
      chk("full.rem", remaining, 8'(3 - k / 10));
      chk("full.done", 8'(done), 8'(k == 30));
      chk("full.state", 8'(state), (k < 30) ? 8'd1 : 8'd3);
    end
    cyc(1);
    chk_all("expired_hold", 2'b11, 8'd0, 1'b0, 1'b0);

    // EXPIRED: start ignored, load returns to IDLE
    start = 1'b1; cyc(1); start = 1'b0;
    chk_all("exp_start_ign", 2'b11, 8'd0, 1'b0, 1'b0);
    load = 1'b1; load_val = 8'd5; cyc(1); load = 1'b0;
    chk_all("exp_load5", 2'b00, 8'd5, 1'b0, 1'b0);

    // reset mid-RUN
    start = 1'b1; cyc(1); start = 1'b0;
    chk("run5.state", 8'(state), 8'd1);
    cyc(3);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk_all("reset_midrun", 2'b00, 8'd0, 1'b0, 1'b0);

    // start with zero count is ignored
    load = 1'b1; load_val = 8'd0; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    chk_all("start_zero", 2'b00, 8'd0, 1'b0, 1'b0);

    // load and start together: load wins
    load = 1'b1; start = 1'b1; load_val = 8'd7; cyc(1); load = 1'b0; start = 1'b0;
    chk_all("load_start", 2'b00, 8'd7, 1'b0, 1'b0);

    // pause/resume: load 2, E0, pause at E0+4, 5 paused cycles, resume at E0+10
    load = 1'b1; load_val = 8'd2; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(3);
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk_all("paused", 2'b10, 8'd2, 1'b0, 1'b0);
    for (int k = 5; k <= 9; k++) begin
      cyc(1);
      chk("pause.tick", 8'(tick), 8'd0);
      chk("pause.state", 8'(state), 8'd2);
    end
    start = 1'b1; cyc(1); start = 1'b0;
    chk_all("resume", 2'b01, 8'd2, 1'b0, 1'b0);
    for (int k = 11; k <= 27; k++) begin
      cyc(1);
      chk("pr.tick", 8'(tick), 8'(k == 17 || k == 27));
      chk("pr.rem", remaining, (k < 17) ? 8'd2 : (k < 27) ? 8'd1 : 8'd0);
      chk("pr.done", 8'(done), 8'(k == 27));
    end

    // pause sampled on prescaler=9
    load = 1'b1; load_val = 8'd3; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(9);
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk_all("pause_wrap", 2'b10, 8'd3, 1'b0, 1'b0);
    start = 1'b1; pause = 1'b1; cyc(1); pause = 1'b0;
    chk_all("start_pause_both", 2'b10, 8'd3, 1'b0, 1'b0);
    cyc(1); start = 1'b0;
    chk_all("resume_wrap", 2'b01, 8'd3, 1'b0, 1'b0);
    cyc(1);
    chk_all("wrap_tick", 2'b01, 8'd2, 1'b1, 1'b0);

    // load ignored in RUN
    load = 1'b1; load_val = 8'd50; cyc(1); load = 1'b0;
    chk_all("run_load_ign", 2'b01, 8'd2, 1'b0, 1'b0);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk_all("clear_run", 2'b00, 8'd0, 1'b0, 1'b0);

    // clear coincident with the final wrap
    load = 1'b1; load_val = 8'd1; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(9);
    chk_all("pre_final", 2'b01, 8'd1, 1'b0, 1'b0);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk_all("clear_final", 2'b00, 8'd0, 1'b0, 1'b0);
    cyc(1);
    chk_all("clear_after", 2'b00, 8'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
